fifo_read_ctrl: RTL and testbench

- Read-domain control stage of the async FIFO; sits directly upstream of the read-pointer counter (fifo_read).
- Synchronises the write pointer into r_clk with a 2-flop Gray synchroniser and compares it against the local read pointer.
- Produces r_en for the pointer counter only when a read is legal, plus the registered empty flag, fill level, the read pointer in Gray code for the write domain, and a read-data-valid strobe.

---
 rtl/fifo_read_ctrl.sv | 89 ++++++++
 tb/tb_fifo_read_ctrl.sv | 263 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/fifo_read_ctrl.sv
// Read-domain control for the async FIFO: write-pointer synchroniser, empty/level flags, Gray read
// pointer and read strobes. Optional almost-empty flag is enabled by defining FIFO_ALMOST_EMPTY_EN.
module fifo_read_ctrl #(
  parameter int unsigned add_size = 3,
  parameter int unsigned AE_LEVEL = 2
) (
  input  logic              r_clk,
  input  logic              rst,
  input  logic              rd_req,
  input  logic [add_size:0] r_add,
  input  logic [add_size:0] wptr_gray,
  output logic              r_en,
  output logic              empty,
  output logic [add_size:0] rptr_gray,
  output logic [add_size:0] rd_level,
  output logic              rd_valid,
`ifdef FIFO_ALMOST_EMPTY_EN
  output logic              almost_empty,
`endif
  output logic              underflow
);

  localparam int unsigned PtrW = add_size + 1;
  localparam logic [add_size:0] AeLevel = PtrW'(AE_LEVEL);

  logic [add_size:0] wq1;
  logic [add_size:0] wq2;
  logic [add_size:0] wq2_next;
  logic [add_size:0] rbin_next;
  logic [add_size:0] rgray_next;
  logic [add_size:0] wbin_sync;
  logic [add_size:0] level_next;
  logic              empty_next;

  // empty is registered, so gating on it never lets the counter advance past the write pointer.
  assign r_en = rd_req & ~empty;

  // Flags are loaded from the value wq2 takes on this same edge, so a write is reflected exactly two
  // edges after wptr_gray settles and a last-entry read racing a new write keeps empty low.
  always_comb begin
    wq2_next   = wq1;
    rbin_next  = r_add + PtrW'(r_en);
    rgray_next = rbin_next ^ (rbin_next >> 1);
    wbin_sync  = '0;
    for (int unsigned i = 0; i < PtrW; i++) begin
      wbin_sync[i] = ^(wq2_next >> i);
    end
    empty_next = (rgray_next == wq2_next);
    level_next = wbin_sync - rbin_next;
  end

  always_ff @(posedge r_clk) begin
    if (rst) begin
      wq1       <= '0;
      wq2       <= '0;
      rptr_gray <= '0;
      empty     <= 1'b1;
      rd_level  <= '0;
      rd_valid  <= 1'b0;
      underflow <= 1'b0;
    end else begin
      wq1       <= wptr_gray;
      wq2       <= wq2_next;
      rptr_gray <= rgray_next;
      empty     <= empty_next;
      rd_level  <= level_next;
      rd_valid  <= r_en;
      underflow <= underflow | (rd_req & empty);
    end
  end

`ifdef FIFO_ALMOST_EMPTY_EN
  always_ff @(posedge r_clk) begin
    if (rst) begin
      almost_empty <= 1'b1;
    end else begin
      almost_empty <= (level_next <= AeLevel);
    end
  end
`else
  logic unused_ae_level;
  assign unused_ae_level = ^AeLevel;
`endif

  // wq2 is the synchroniser's second stage; downstream flops load from its next-state directly.
  logic unused_wq2;
  assign unused_wq2 = ^wq2;

endmodule

// File: tb/tb_fifo_read_ctrl.sv
// Scoreboard bench for fifo_read_ctrl: stimulus queues expected snapshots and read data, a monitor
// compares them on the falling clock edge.
module tb_fifo_read_ctrl;

  logic       r_clk = 1'b0;
  logic       rst;
  logic       rd_req;
  logic [3:0] r_add;
  logic [3:0] wptr_gray;
  logic       r_en;
  logic       empty;
  logic [3:0] rptr_gray;
  logic [3:0] rd_level;
  logic       rd_valid;
  logic       underflow;
`ifdef FIFO_ALMOST_EMPTY_EN
  logic       almost_empty;
`endif

  fifo_read_ctrl #(
    .add_size(3),
    .AE_LEVEL(2)
  ) dut (
    .r_clk       (r_clk),
    .rst         (rst),
    .rd_req      (rd_req),
    .r_add       (r_add),
    .wptr_gray   (wptr_gray),
    .r_en        (r_en),
    .empty       (empty),
    .rptr_gray   (rptr_gray),
    .rd_level    (rd_level),
    .rd_valid    (rd_valid),
`ifdef FIFO_ALMOST_EMPTY_EN
    .almost_empty(almost_empty),
`endif
    .underflow   (underflow)
  );

  always #5 r_clk = ~r_clk;

  typedef struct {
    int         cyc;
    string      nm;
    logic       e;
    logic       ren;
    logic [3:0] rp;
    logic [3:0] lvl;
    logic       rv;
    logic       uf;
    logic       ae;
  } snap_t;

  snap_t      exp_q[$];
  snap_t      s_mon;
  logic [7:0] dq[$];
  logic [7:0] mem[8];
  logic [7:0] rd_data;
  logic [7:0] wdata = 8'hA0;
  logic [3:0] wbin;
  logic [3:0] occ;
  logic [3:0] prev_radd;
  logic [3:0] prev_rptr;
  int         cyc = 0;
  int         n_chk = 0;
  int         n_fail = 0;
  bit         stream_chk = 1'b0;
  bit         wrap_seen = 1'b0;

  logic [3:0] gtab[5]  = '{4'b0101, 4'b0100, 4'b1100, 4'b1101, 4'b1111};
  logic [3:0] ltab[5]  = '{4'd4, 4'd3, 4'd2, 4'd1, 4'd0};
  logic       aetab[5] = '{1'b0, 1'b0, 1'b1, 1'b1, 1'b1};

  function automatic logic [3:0] g(input logic [3:0] b);
    return b ^ (b >> 1);
  endfunction

  task automatic chk(input string nm, input logic [7:0] act, input logic [7:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", nm, act, exp, cyc);
    end
  endtask

  // Read-pointer counter and registered memory read as seen downstream of the DUT.
  always @(posedge r_clk) begin
    cyc <= cyc + 1;
    if (rst) r_add <= 4'd0;
    else if (r_en) r_add <= r_add + 4'd1;
    if (r_en === 1'b1) rd_data <= mem[r_add[2:0]];
  end

  always @(negedge r_clk) begin
    while (exp_q.size() > 0 && exp_q[0].cyc <= cyc) begin
      s_mon = exp_q.pop_front();
      chk({s_mon.nm, " empty"},     8'(empty),     8'(s_mon.e));
      chk({s_mon.nm, " r_en"},      8'(r_en),      8'(s_mon.ren));
      chk({s_mon.nm, " rptr_gray"}, 8'(rptr_gray), 8'(s_mon.rp));
      chk({s_mon.nm, " rd_level"},  8'(rd_level),  8'(s_mon.lvl));
      chk({s_mon.nm, " rd_valid"},  8'(rd_valid),  8'(s_mon.rv));
      chk({s_mon.nm, " underflow"}, 8'(underflow), 8'(s_mon.uf));
`ifdef FIFO_ALMOST_EMPTY_EN
      chk({s_mon.nm, " almost_empty"}, 8'(almost_empty), 8'(s_mon.ae));
`endif
    end
    if (rd_valid === 1'b1) begin
      if (dq.size() == 0) begin
        n_chk++;
        n_fail++;
        $display("FAIL rd_valid: got 1 with no entry outstanding, expected 0 (cycle %0d)", cyc);
      end else begin
        chk("rd_data", rd_data, dq.pop_front());
      end
    end
    if (stream_chk) begin
      occ = wbin - r_add;
      chk("stream rptr_gray vs r_add", 8'(rptr_gray), 8'(g(r_add)));
      chk("stream rd_level within occupancy", 8'(rd_level <= occ), 8'd1);
      chk("stream rd_level at most 8", 8'(rd_level <= 4'd8), 8'd1);
      if (empty === 1'b0) chk("stream empty low only when occupied", 8'(occ != 4'd0), 8'd1);
      if (r_add == 4'd0 && prev_radd == 4'd15) begin
        wrap_seen = 1'b1;
        chk("wrap rptr_gray before", 8'(prev_rptr), 8'b1000);
        chk("wrap rptr_gray after", 8'(rptr_gray), 8'b0000);
      end
    end
    prev_radd = r_add;
    prev_rptr = rptr_gray;
  end

  task automatic step();
    @(posedge r_clk);
    #1;
  endtask

  task automatic exp_now(input string nm, input logic e, input logic ren, input logic [3:0] rp,
                         input logic [3:0] lvl, input logic rv, input logic uf, input logic ae);
    snap_t s;
    s.cyc = cyc; s.nm = nm; s.e = e; s.ren = ren; s.rp = rp;
    s.lvl = lvl; s.rv = rv; s.uf = uf; s.ae = ae;
    exp_q.push_back(s);
  endtask

  task automatic do_write();
    mem[wbin[2:0]] = wdata;
    dq.push_back(wdata);
    wdata     = wdata + 8'd1;
    wbin      = wbin + 4'd1;
    wptr_gray = g(wbin);
  endtask

  initial begin
    #100000;
    $display("FAIL global timeout: got no end of test, expected completion");
    $fatal(1);
  end

  initial begin
    int written;
    int guard;
    rst       = 1'b1;
    rd_req    = 1'b1;
    wptr_gray = 4'b0101;
    wbin      = 4'd0;
    step();
    step();
    exp_now("in reset", 1'b1, 1'b0, 4'd0, 4'd0, 1'b0, 1'b0, 1'b1);
    rst       = 1'b0;
    rd_req    = 1'b0;
    wptr_gray = 4'd0;
    step();
    exp_now("after reset", 1'b1, 1'b0, 4'd0, 4'd0, 1'b0, 1'b0, 1'b1);

    // One write: empty must fall on exactly the second edge.
    do_write();
    step();
    exp_now("write edge 1", 1'b1, 1'b0, 4'd0, 4'd0, 1'b0, 1'b0, 1'b1);
    step();
    exp_now("write edge 2", 1'b0, 1'b0, 4'd0, 4'd1, 1'b0, 1'b0, 1'b1);
    step();
    rd_req = 1'b1;
    exp_now("single read req", 1'b0, 1'b1, 4'd0, 4'd1, 1'b0, 1'b0, 1'b1);
    step();
    rd_req = 1'b0;
    exp_now("single read done", 1'b1, 1'b0, 4'b0001, 4'd0, 1'b1, 1'b0, 1'b1);
    step();
    exp_now("single read idle", 1'b1, 1'b0, 4'b0001, 4'd0, 1'b0, 1'b0, 1'b1);

    // Streaming: 20 writes, consumer reads whenever not empty; pointers wrap.
    stream_chk = 1'b1;
    written = 0;
    guard = 0;
    while (written < 20 && guard < 200) begin
      rd_req = ~empty;
      if (4'(wbin - r_add) < 4'd8) begin
        do_write();
        written++;
      end
      step();
      guard++;
    end
    guard = 0;
    while (dq.size() > 0 && guard < 50) begin
      rd_req = ~empty;
      step();
      guard++;
    end
    if (dq.size() > 0) begin
      n_chk++;
      n_fail++;
      $display("FAIL stream drain: got %0d entries left, expected 0", dq.size());
    end
    rd_req = 1'b0;
    step();
    step();
    step();
    stream_chk = 1'b0;
    chk("stream wrap observed", 8'(wrap_seen), 8'd1);
    exp_now("post-stream", 1'b1, 1'b0, 4'b0111, 4'd0, 1'b0, 1'b0, 1'b1);
    step();

    // Fill to 5 then drain one entry at a time.
    for (int k = 0; k < 5; k++) begin
      do_write();
      step();
    end
    step();
    step();
    step();
    exp_now("fill level 5", 1'b0, 1'b0, 4'b0111, 4'd5, 1'b0, 1'b0, 1'b0);
    step();
    for (int k = 0; k < 5; k++) begin
      rd_req = 1'b1;
      step();
      rd_req = 1'b0;
      exp_now($sformatf("drain %0d", k), (k == 4), 1'b0, gtab[k], ltab[k], 1'b1, 1'b0, aetab[k]);
      step();
    end

    // Underflow: request while empty, sticky until reset.
    rd_req = 1'b1;
    exp_now("underflow pre-edge", 1'b1, 1'b0, 4'b1111, 4'd0, 1'b0, 1'b0, 1'b1);
    for (int k = 0; k < 3; k++) begin
      step();
      exp_now("underflow sticky", 1'b1, 1'b0, 4'b1111, 4'd0, 1'b0, 1'b1, 1'b1);
    end
    rd_req = 1'b0;
    step();
    exp_now("underflow hold", 1'b1, 1'b0, 4'b1111, 4'd0, 1'b0, 1'b1, 1'b1);
    step();
    rst = 1'b1;
    step();
    exp_now("reset clears", 1'b1, 1'b0, 4'd0, 4'd0, 1'b0, 1'b0, 1'b1);
    @(negedge r_clk);
    #1;
    chk("expectations consumed", 8'(exp_q.size()), 8'd0);
    chk("read data consumed", 8'(dq.size()), 8'd0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
